// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM encoding, default timing and field constants for the LCD controllers
package lcd_pkg;
  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_EN_HI, S_EN_LO, S_DONE} lcd_state_t;
  localparam int T_SETUP_DEF = 3;
  localparam int T_EN_HIGH_DEF = 16;
  localparam int T_EN_LOW_DEF = 16;
  localparam int POLL_TIMEOUT_DEF = 50000;
  localparam logic RS_CMD = 1'b0;
  localparam logic RS_DATA = 1'b1;
  localparam int BF_BIT = 7;
  function automatic int tmax(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/lcd_phase_timer.sv
// lcd_phase_timer: loadable down-counter that stops at zero and flags it
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= value;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/lcd_read_ctrl.sv
// lcd_read_ctrl: HD44780 read-cycle controller for status (BF+AC) or data RAM, with optional busy polling
module lcd_read_ctrl
  import lcd_pkg::*;
#(
  parameter int T_SETUP = T_SETUP_DEF,
  parameter int T_EN_HIGH = T_EN_HIGH_DEF,
  parameter int T_EN_LOW = T_EN_LOW_DEF,
  parameter int POLL_TIMEOUT = POLL_TIMEOUT_DEF
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iREQ,
  input  logic       iRS,
  input  logic       iPOLL,
  inout  wire  [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN,
  output logic       oREADY,
  output logic       oDONE,
  output logic [7:0] oDATA,
  output logic       oBUSY_FLAG,
  output logic [6:0] oADDR,
  output logic       oTIMEOUT
);
  localparam int TW = $clog2(tmax(tmax(T_SETUP, T_EN_HIGH), tmax(T_EN_LOW, 2)));
  localparam int SW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [SW-1:0] PT = SW'(POLL_TIMEOUT);
  lcd_state_t state, nxt;
  logic rs, poll, load, zero, accept, sample, retry, active;
  logic [TW-1:0] ld_val;
  logic [SW-1:0] strobes;
  assign LCD_DATA = 8'hzz;
  // oDONE lags the DONE state by a cycle, so that cycle still counts as busy
  assign oREADY = state == S_IDLE && !oDONE;
  assign accept = oREADY && iREQ;
  assign sample = state == S_EN_HI && zero;
  assign active = state inside {S_SETUP, S_EN_HI, S_EN_LO};
  assign retry = poll && oBUSY_FLAG && strobes < PT;
  lcd_phase_timer #(.W(TW)) u_timer (
    .clk(iCLK), .rst_n(iRST_N), .load(load), .value(ld_val), .zero(zero)
  );
  always_comb begin
    nxt = state;
    load = 1'b0;
    ld_val = TW'(T_SETUP - 1);
    case (state)
      S_IDLE: if (accept) begin nxt = S_SETUP; load = 1'b1; end
      S_SETUP: if (zero) begin nxt = S_EN_HI; load = 1'b1; ld_val = TW'(T_EN_HIGH - 1); end
      S_EN_HI: if (zero) begin nxt = S_EN_LO; load = 1'b1; ld_val = TW'(T_EN_LOW - 1); end
      S_EN_LO: if (zero) begin nxt = retry ? S_SETUP : S_DONE; load = retry; end
      default: nxt = S_IDLE;
    endcase
  end
  // LCD pins are registered copies of the state so they cannot glitch
  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state <= S_IDLE;
      rs <= RS_CMD;
      poll <= 1'b0;
      strobes <= '0;
      LCD_EN <= 1'b0;
      LCD_RW <= 1'b0;
      LCD_RS <= 1'b0;
      oDONE <= 1'b0;
      oTIMEOUT <= 1'b0;
      oDATA <= 8'h00;
      oBUSY_FLAG <= 1'b0;
      oADDR <= 7'h00;
    end else begin
      state <= nxt;
      LCD_EN <= state == S_EN_HI;
      LCD_RW <= active;
      LCD_RS <= active && rs;
      oDONE <= state == S_DONE;
      oTIMEOUT <= state == S_DONE && poll && oBUSY_FLAG && strobes == PT;
      if (accept) begin
        rs <= iPOLL ? RS_CMD : iRS;
        poll <= iPOLL;
        strobes <= '0;
      end
      if (sample) begin
        oDATA <= LCD_DATA;
        oBUSY_FLAG <= rs == RS_CMD && LCD_DATA[BF_BIT];
        if (rs == RS_CMD) oADDR <= LCD_DATA[6:0];
        if (strobes != PT) strobes <= strobes + 1'b1;
      end
    end
endmodule

// File: tb/tb_lcd_read_ctrl.sv
// tb_lcd_read_ctrl: scoreboard bench with an LCD bus model and an EN/RS/RW timing checker
module tb_lcd_read_ctrl;
  logic clk = 0, rst_n = 0, req = 0, rs = 0, poll = 0;
  logic [7:0] bus_val = 8'h00;
  wire [7:0] lcd_data;
  logic lcd_rs, lcd_rw, lcd_en, ready, done, busy_flag, timeout;
  logic [7:0] data;
  logic [6:0] addr;
  typedef struct {
    logic [7:0] d;
    logic bf;
    logic [6:0] a;
    logic tmo;
    int lat;
    int t0;
  } exp_t;
  exp_t sb[$];
  logic [7:0] rq[$];
  int errors = 0, checks = 0, cyc = 0, en_pulses = 0, done_cnt = 0;
  int hi = 0, lo = 100, stab = 100;
  logic prev_en = 0, exp_rs = 0;
  logic [1:0] prev_rsrw = 2'b00;

  assign lcd_data = bus_val;
  always #10 clk = ~clk;
  always @(posedge clk) cyc++;

  lcd_read_ctrl #(.POLL_TIMEOUT(4)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .iRS(rs), .iPOLL(poll),
    .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .oREADY(ready), .oDONE(done), .oDATA(data), .oBUSY_FLAG(busy_flag),
    .oADDR(addr), .oTIMEOUT(timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // LCD model: each strobe consumes one queued response byte
  always @(negedge lcd_en) begin
    if (rq.size() > 0) void'(rq.pop_front());
    bus_val = rq.size() > 0 ? rq[0] : 8'h00;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sb.pop_front();
        chk("data", data, e.d);
        chk("busy_flag", busy_flag, e.bf);
        chk("addr", addr, e.a);
        chk("timeout", timeout, e.tmo);
        chk("latency", cyc - e.t0, e.lat);
      end
    end else if (timeout) chk("timeout_without_done", timeout, 0);
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      hi = 0; lo = 100; stab = 100; prev_en = 0; prev_rsrw = 2'b00;
    end else begin
      if (lcd_en && !prev_en) begin
        chk("en_low_width_ok", lo >= 16, 1);
        chk("rsrw_setup_ok", stab >= 3, 1);
        chk("rs_during_en", lcd_rs, exp_rs);
        chk("rw_during_en", lcd_rw, 1);
        en_pulses++;
        hi = 0;
      end
      if (!lcd_en && prev_en) begin
        chk("en_high_width", hi, 16);
        lo = 0;
      end
      if (lcd_en && prev_en) chk("rsrw_stable_en", {lcd_rs, lcd_rw}, prev_rsrw);
      if ({lcd_rs, lcd_rw} !== prev_rsrw) stab = 0;
      if (lcd_en) hi++;
      else lo++;
      stab++;
      prev_en = lcd_en;
      prev_rsrw = {lcd_rs, lcd_rw};
    end
  end

  task automatic read_op(input logic r, input logic p, input int n, input logic [31:0] bytes,
                         input logic [7:0] ed, input logic ebf, input logic [6:0] ea,
                         input logic etmo, input int elat, input int epulses, input logic poke);
    int p0;
    @(negedge clk);
    for (int i = 0; i < 100 && !ready; i++) @(negedge clk);
    chk("ready_before_req", ready, 1);
    rq.delete();
    for (int k = 0; k < n; k++) rq.push_back(bytes[8*k +: 8]);
    bus_val = rq[0];
    exp_rs = p ? 1'b0 : r;
    sb.push_back('{ed, ebf, ea, etmo, elat, cyc + 1});
    p0 = en_pulses;
    req = 1; rs = r; poll = p;
    @(negedge clk);
    req = 0;
    if (poke) begin
      repeat (10) @(negedge clk);
      chk("ready_while_busy", ready, 0);
      req = 1; rs = ~r;
      @(negedge clk);
      req = 0;
    end
    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("done_within_budget", 0, 1);
      sb.delete();
    end
    chk("en_pulse_count", en_pulses - p0, epulses);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    repeat (3) @(negedge clk);
    chk("rst_en", lcd_en, 0);
    chk("rst_rw", lcd_rw, 0);
    chk("rst_rs", lcd_rs, 0);
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_data", data, 0);
    chk("rst_bf", busy_flag, 0);
    chk("rst_addr", addr, 0);
    chk("rst_timeout", timeout, 0);
    rst_n = 1;
    read_op(0, 0, 1, 32'h85, 8'h85, 1, 7'h05, 0, 36, 1, 1);
    read_op(1, 0, 1, 32'h41, 8'h41, 0, 7'h05, 0, 36, 1, 0);
    read_op(0, 1, 4, 32'h0C8C8B8A, 8'h0C, 0, 7'h0C, 0, 141, 4, 0);
    read_op(0, 1, 4, 32'hC3C3C3C3, 8'hC3, 1, 7'h43, 1, 141, 4, 0);
    read_op(1, 1, 1, 32'h25, 8'h25, 0, 7'h25, 0, 36, 1, 0);
    rq.delete();
    rq.push_back(8'h99);
    bus_val = 8'h99;
    exp_rs = 0;
    req = 1; rs = 0; poll = 0;
    @(negedge clk);
    req = 0;
    for (int i = 0; i < 100 && !lcd_en; i++) @(negedge clk);
    chk("en_reached_before_reset", lcd_en, 1);
    repeat (5) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midreset_en", lcd_en, 0);
    chk("midreset_rw", lcd_rw, 0);
    chk("midreset_ready", ready, 1);
    chk("midreset_data", data, 0);
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (60) @(negedge clk);
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("ready_after_reset", ready, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
